// File: rtl/fir_sample_sequencer.sv
// Paces samples from a small input FIFO into one fir_filter (one sample every DIV clocks),
// captures the filter output LAT clocks after each issue, and drains/zero-flushes on stop.
module fir_sample_sequencer #(
  parameter int DATA_W  = 8,
  parameter int DIV     = 20,
  parameter int DEPTH   = 4,
  parameter int LAT     = 1,
  parameter int FLUSH_N = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] fir_in,
  output logic              fir_ready,
  input  logic [DATA_W-1:0] fir_out,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              underrun,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DIV);
  localparam int FL_W  = $clog2(FLUSH_N + 1);
  localparam int LAT_W = $clog2(LAT + 1);

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
  localparam logic [FL_W-1:0]  FLUSH_LD  = FL_W'(FLUSH_N - 1);
  localparam logic [LAT_W-1:0] LAT_LD    = LAT_W'(LAT);
  localparam logic [LAT_W-1:0] LAT_FIRE  = LAT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_FLUSH = 2'd3
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FL_W-1:0]    flush_q;
  logic [LAT_W-1:0]   cap_q;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [DATA_W-1:0]  fir_in_q;
  logic               fir_ready_q;
  logic [DATA_W-1:0]  out_data_q;
  logic               out_valid_q;
  logic               underrun_q;

  logic               tick;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  head;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready
  // depends only on FIFO occupancy, so the producer must hold data until it is taken.
  assign fifo_empty = (occ_q == '0);
  assign fifo_full  = (occ_q == OCC_FULL);
  assign push       = in_valid && !fifo_full;
  assign tick       = (state_q != S_IDLE) && (cnt_q == DIV_LAST);
  assign pop        = tick && !fifo_empty && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if ((state_q == S_IDLE) || tick) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: the pointers and occupancy define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      flush_q     <= '0;
      fir_in_q    <= '0;
      fir_ready_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          fir_in_q    <= '0;
          fir_ready_q <= 1'b0;
          if (en) begin
            state_q     <= S_RUN;
            fir_ready_q <= 1'b1;
            underrun_q  <= 1'b0;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (!fifo_empty) begin
              fir_in_q <= head;
            end else begin
              fir_in_q   <= '0;
              underrun_q <= 1'b1;
            end
          end
          if (!en) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tick) begin
            if (!fifo_empty) begin
              fir_in_q <= head;
            end else begin
              fir_in_q <= '0;
              flush_q  <= FLUSH_LD;
              state_q  <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          if (tick) begin
            fir_in_q <= '0;
            if (flush_q == '0) begin
              state_q     <= S_IDLE;
              fir_ready_q <= 1'b0;
            end else begin
              flush_q <= flush_q - 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Every issuing tick arms a LAT-cycle countdown; DIV >= LAT+2 keeps captures disjoint.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (tick) begin
        cap_q <= LAT_LD;
      end else if (cap_q != '0) begin
        cap_q <= cap_q - 1'b1;
      end
      out_valid_q <= (cap_q == LAT_FIRE);
      if (cap_q == LAT_FIRE) begin
        out_data_q <= fir_out;
      end
    end
  end

  assign in_ready  = !fifo_full;
  assign fir_in    = fir_in_q;
  assign fir_ready = fir_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;
  assign busy      = (state_q != S_IDLE) || (cap_q != '0) || out_valid_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Bench for fir_sample_sequencer: directed scenarios with literal pins plus a random phase,
// all outputs compared every cycle against a queue-based behavioural model.
module tb_fir_sample_sequencer;

  localparam int DATA_W  = 8;
  localparam int DIV     = 20;
  localparam int DEPTH   = 4;
  localparam int LAT     = 1;
  localparam int FLUSH_N = 3;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] fir_in;
  logic              fir_ready;
  logic [DATA_W-1:0] fir_out = '0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              underrun;
  logic              busy;
  logic [1:0]        dbg_state;

  always #5 clk = ~clk;

  fir_sample_sequencer #(
    .DATA_W (DATA_W),
    .DIV    (DIV),
    .DEPTH  (DEPTH),
    .LAT    (LAT),
    .FLUSH_N(FLUSH_N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .fir_in   (fir_in),
    .fir_ready(fir_ready),
    .fir_out  (fir_out),
    .out_data (out_data),
    .out_valid(out_valid),
    .underrun (underrun),
    .busy     (busy),
    .dbg_state(dbg_state)
  );

  // Stand-in filter: a fresh random output every cycle, changed just after each edge,
  // so a capture on the wrong cycle picks up a different value.
  always @(posedge clk) begin
    #1 fir_out = DATA_W'($urandom);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_FLUSH = 3;

  logic [DATA_W-1:0] exp_q[$];
  int                m_mode = M_IDLE;
  int                m_mode0;
  int                m_phase = 0;
  int                m_flush_rem = 0;
  longint            m_cyc = 0;
  longint            m_cap_cyc = -1;
  logic [DATA_W-1:0] m_fir_in = '0;
  logic [DATA_W-1:0] m_out_data = '0;
  logic              m_out_valid = 1'b0;
  logic              m_underrun = 1'b0;
  logic              m_fir_ready = 1'b0;
  bit                m_tick;
  bit                m_can_push;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_mode      = M_IDLE;
      m_phase     = 0;
      m_flush_rem = 0;
      m_cyc       = 0;
      m_cap_cyc   = -1;
      m_fir_in    = '0;
      m_out_data  = '0;
      m_out_valid = 1'b0;
      m_underrun  = 1'b0;
      m_fir_ready = 1'b0;
    end else begin
      m_mode0    = m_mode;
      m_can_push = (exp_q.size() < DEPTH);
      m_tick     = (m_mode0 != M_IDLE) && ((m_phase % DIV) == DIV - 1);
      m_cyc++;
      m_out_valid = (m_cyc == m_cap_cyc);
      if (m_out_valid) m_out_data = fir_out;
      if (m_mode0 != M_IDLE) m_phase++;
      if (m_tick) begin
        m_cap_cyc = m_cyc + LAT;
        if (m_mode0 == M_FLUSH) begin
          m_fir_in = '0;
          m_flush_rem--;
          if (m_flush_rem == 0) begin
            m_mode      = M_IDLE;
            m_fir_ready = 1'b0;
          end
        end else if (exp_q.size() > 0) begin
          m_fir_in = exp_q.pop_front();
        end else begin
          m_fir_in = '0;
          if (m_mode0 == M_RUN) begin
            m_underrun = 1'b1;
          end else begin
            m_mode      = M_FLUSH;
            m_flush_rem = FLUSH_N;
          end
        end
      end
      if (m_mode0 == M_IDLE && en) begin
        m_mode      = M_RUN;
        m_phase     = 0;
        m_underrun  = 1'b0;
        m_fir_ready = 1'b1;
      end
      if (m_mode0 == M_RUN && !en) m_mode = M_DRAIN;
      if (in_valid && m_can_push) exp_q.push_back(in_data);
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("in_ready",  in_ready,  (exp_q.size() < DEPTH));
    check("fir_in",    fir_in,    m_fir_in);
    check("fir_ready", fir_ready, m_fir_ready);
    check("out_valid", out_valid, m_out_valid);
    check("out_data",  out_data,  m_out_data);
    check("underrun",  underrun,  m_underrun);
    check("busy",      busy,      (m_mode != M_IDLE) || (m_cap_cyc >= m_cyc));
  end

  // ---------------- driver tasks ----------------
  int cur = 0;

  task automatic go();
    en = 1'b1;
    @(negedge clk);
    cur = 0;
  endtask

  task automatic wait_edge(input int k);
    while (cur < k) begin
      @(negedge clk);
      cur++;
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic stop_idle();
    int n;
    n = 0;
    en = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    check("reach_idle", busy, 1'b0);
  endtask

  logic [DATA_W-1:0] fo;
  logic [DATA_W-1:0] steady_v[3] = '{8'h10, 8'h20, 8'h30};

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_busy",      busy,      1'b0);
    check("rst_fir_ready", fir_ready, 1'b0);
    check("rst_fir_in",    fir_in,    8'h00);
    rst_n = 1'b1;
    @(negedge clk);

    // Steady stream
    for (int i = 0; i < 3; i++) push(steady_v[i]);
    go();
    for (int k = 1; k <= 3; k++) begin
      wait_edge(20 * k);
      check("steady_fir_in", fir_in, steady_v[k-1]);
      check("steady_nostrobe", out_valid, 1'b0);
      fo = fir_out;
      wait_edge(20 * k + 1);
      check("steady_strobe", out_valid, 1'b1);
      check("steady_out_data", out_data, fo);
    end
    check("steady_underrun", underrun, 1'b0);
    stop_idle();

    // FIFO full with held fifth value
    for (int i = 1; i <= 4; i++) push(DATA_W'(8'hA0 + i));
    check("full_ready_low", in_ready, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("full_held", in_ready, 1'b0);
    go();
    wait_edge(20);
    check("full_first_pop", fir_in, 8'hA1);
    check("full_ready_back", in_ready, 1'b1);
    wait_edge(21);
    in_valid = 1'b0;
    check("full_fifth_taken", in_ready, 1'b0);
    wait_edge(100);
    check("full_fifth_issued", fir_in, 8'hA5);
    stop_idle();

    // Underrun
    go();
    wait_edge(20);
    check("ur_fir_in", fir_in, 8'h00);
    check("ur_flag", underrun, 1'b1);
    wait_edge(21);
    check("ur_strobe", out_valid, 1'b1);
    wait_edge(25);
    in_valid = 1'b1;
    in_data  = 8'h5C;
    wait_edge(26);
    in_valid = 1'b0;
    wait_edge(40);
    check("ur_late_push", fir_in, 8'h5C);
    check("ur_sticky_run", underrun, 1'b1);
    stop_idle();
    check("ur_sticky_idle", underrun, 1'b1);

    // Drain and flush
    push(8'h71);
    push(8'h72);
    go();
    check("df_ur_cleared", underrun, 1'b0);
    wait_edge(10);
    en = 1'b0;
    wait_edge(20);
    check("df_d1", fir_in, 8'h71);
    wait_edge(40);
    check("df_d2", fir_in, 8'h72);
    wait_edge(119);
    check("df_fir_ready_flush", fir_ready, 1'b1);
    wait_edge(120);
    check("df_fir_ready_idle", fir_ready, 1'b0);
    check("df_busy_pending", busy, 1'b1);
    wait_edge(121);
    check("df_last_strobe", out_valid, 1'b1);
    check("df_busy_strobe", busy, 1'b1);
    wait_edge(122);
    check("df_busy_fall", busy, 1'b0);
    stop_idle();

    // Simultaneous push and pop across pointer wrap
    push(8'h01);
    push(8'h02);
    go();
    for (int k = 1; k <= 10; k++) begin
      wait_edge(20 * k - 1);
      in_valid = 1'b1;
      in_data  = DATA_W'(8'h80 + k);
      wait_edge(20 * k);
      in_valid = 1'b0;
      check("pp_order", fir_in, (k == 1) ? 8'h01 : (k == 2) ? 8'h02 : DATA_W'(8'h80 + k - 2));
    end
    stop_idle();

    // Async reset mid-run
    for (int i = 1; i <= 4; i++) push(DATA_W'(8'hB0 + i));
    go();
    wait_edge(25);
    check("ar_before", fir_in, 8'hB1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_fir_in",    fir_in,    8'h00);
    check("ar_fir_ready", fir_ready, 1'b0);
    check("ar_out_data",  out_data,  8'h00);
    check("ar_out_valid", out_valid, 1'b0);
    check("ar_busy",      busy,      1'b0);
    check("ar_in_ready",  in_ready,  1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cur = 0;
    wait_edge(19);
    check("ar_no_early_tick", underrun, 1'b0);
    wait_edge(20);
    check("ar_first_zero", fir_in, 8'h00);
    check("ar_underrun", underrun, 1'b1);
    stop_idle();

    // Random traffic with random stop/start
    en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) == 0);
      in_data  = DATA_W'($urandom);
      if ($urandom_range(0, 199) == 0) en = ~en;
      @(negedge clk);
    end
    stop_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
